// File: rtl/flappy_pkg.sv
// Shared encodings and constants for the pipe scheduler slice.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } game_state_t;

  // Pipe slot word layout: {x, gap_y}
  localparam int unsigned X_MSB   = 31;
  localparam int unsigned X_LSB   = 16;
  localparam int unsigned GAP_MSB = 15;
  localparam int unsigned GAP_LSB = 0;

  localparam logic [15:0] GAP1_INIT = 16'd200;
  localparam logic [15:0] GAP2_INIT = 16'd160;
  localparam logic [15:0] GAP3_INIT = 16'd240;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] gap_init(input int unsigned i);
    case (i)
      0:       return GAP1_INIT;
      1:       return GAP2_INIT;
      default: return GAP3_INIT;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear, saturating at 9999.
module bcd_counter4
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] bcd,
  output logic        changed
);

  logic [15:0] bcd_next;

  // Ripple a +1 through the digits, least significant first
  always_comb begin
    logic carry;
    bcd_next = bcd;
    carry    = 1'b1;
    for (int unsigned d = 0; d < 4; d++) begin
      if (carry) begin
        if (bcd[4*d +: 4] == 4'd9) begin
          bcd_next[4*d +: 4] = 4'd0;
        end else begin
          bcd_next[4*d +: 4] = bcd[4*d +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  // Count register; changed flags only real increments
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bcd     <= '0;
      changed <= 1'b0;
    end else if (inc && (bcd != BCD_MAX)) begin
      bcd     <= bcd_next;
      changed <= 1'b1;
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Game-phase FSM, three-slot pipe scroller with LFSR respawn gaps, BCD score.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SPACING  = 240,
  parameter int SPEED    = 2,
  parameter int PIPE_W   = 52,
  parameter int BIRD_X   = 160,
  parameter int GAP_MIN  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        frame_tick,
  input  logic        fail,
  output logic [31:0] pipe1,
  output logic [31:0] pipe2,
  output logic [31:0] pipe3,
  output logic [15:0] score,
  output logic        score_pulse,
  output logic [1:0]  state
);

  localparam logic [15:0] STEP = 16'(SPEED);
  localparam logic [15:0] WRAP = 16'(3 * SPACING - SPEED);
  localparam logic [15:0] GMIN = 16'(GAP_MIN);
  localparam logic [16:0] PW17 = 17'(PIPE_W);
  localparam logic [16:0] BX17 = 17'(BIRD_X);

  function automatic logic [15:0] x_init(input int unsigned i);
    return 16'(SCREEN_W + int'(i) * SPACING);
  endfunction

  game_state_t state_q, state_d;
  logic        up_q, up_rise, move, restore;
  logic [15:0] lfsr_q;
  logic [15:0] x_q [3];
  logic [15:0] gap_q [3];
  logic [15:0] x_new [3];
  logic [15:0] gap_new [3];
  logic [7:0]  rnd [3];
  logic [2:0]  scored;

  assign up_rise = up & ~up_q;
  assign move    = (state_q == ST_RUN) && frame_tick && !fail;
  assign restore = (state_q == ST_DEAD) && up_rise;

  // Game state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; fail wins over a coincident frame tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (up_rise) state_d = ST_RUN;
      ST_RUN:  if (fail)    state_d = ST_DEAD;
      ST_DEAD: if (up_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Button edge history and free-running gap LFSR
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q   <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else begin
      up_q   <= up;
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Per-slot scroll/respawn and score-line crossing
  always_comb begin
    rnd[0] = lfsr_q[7:0];
    rnd[1] = lfsr_q[12:5];
    rnd[2] = lfsr_q[15:8];
    for (int unsigned i = 0; i < 3; i++) begin
      scored[i] = 1'b0;
      if (x_q[i] <= STEP) begin
        x_new[i]   = x_q[i] + WRAP;
        gap_new[i] = GMIN + {8'd0, rnd[i]};
      end else begin
        x_new[i]   = x_q[i] - STEP;
        gap_new[i] = gap_q[i];
        scored[i]  = (({1'b0, x_q[i]} + PW17) >= BX17) &&
                     (({1'b0, x_new[i]} + PW17) < BX17);
      end
    end
  end

  // Slot registers; DEAD->IDLE restores the power-on layout
  always_ff @(posedge clk) begin
    if (rst || restore) begin
      for (int unsigned i = 0; i < 3; i++) begin
        x_q[i]   <= x_init(i);
        gap_q[i] <= gap_init(i);
      end
    end else if (move) begin
      for (int unsigned i = 0; i < 3; i++) begin
        x_q[i]   <= x_new[i];
        gap_q[i] <= gap_new[i];
      end
    end
  end

  bcd_counter4 u_score (
    .clk     (clk),
    .rst     (rst),
    .clr     (restore),
    .inc     (move && (|scored)),
    .bcd     (score),
    .changed (score_pulse)
  );

  assign pipe1[X_MSB:X_LSB]     = x_q[0];
  assign pipe1[GAP_MSB:GAP_LSB] = gap_q[0];
  assign pipe2[X_MSB:X_LSB]     = x_q[1];
  assign pipe2[GAP_MSB:GAP_LSB] = gap_q[1];
  assign pipe3[X_MSB:X_LSB]     = x_q[2];
  assign pipe3[GAP_MSB:GAP_LSB] = gap_q[2];
  assign state                  = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed self-checking bench for pipe_scheduler and its BCD score counter.
module tb_pipe_scheduler;

  logic        clk = 1'b0;
  logic        rst, up, frame_tick, fail;
  logic [31:0] pipe1, pipe2, pipe3;
  logic [15:0] score;
  logic        score_pulse;
  logic [1:0]  state;

  logic        c_rst, c_clr, c_inc;
  logic [15:0] c_bcd;
  logic        c_chg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_scheduler #(.SCREEN_W(640), .SPACING(240), .SPEED(2),
                   .PIPE_W(52), .BIRD_X(160), .GAP_MIN(60)) dut (
    .clk(clk), .rst(rst), .up(up), .frame_tick(frame_tick), .fail(fail),
    .pipe1(pipe1), .pipe2(pipe2), .pipe3(pipe3),
    .score(score), .score_pulse(score_pulse), .state(state)
  );

  bcd_counter4 u_cnt (
    .clk(clk), .rst(c_rst), .clr(c_clr), .inc(c_inc), .bcd(c_bcd), .changed(c_chg)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11, shifted in at bit 0
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expected game model
  int ex [3];
  int eg [3];
  int exp_score;
  logic exp_pulse;

  task automatic model_reset();
    ex[0] = 640; ex[1] = 880; ex[2] = 1120;
    eg[0] = 200; eg[1] = 160; eg[2] = 240;
    exp_score = 0;
  endtask

  task automatic model_tick(input logic [15:0] l);
    int nx;
    logic any;
    logic [7:0] b [3];
    b[0] = l[7:0]; b[1] = l[12:5]; b[2] = l[15:8];
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ex[i] <= 2) begin
        ex[i] = ex[i] + 718;
        eg[i] = 60 + int'(b[i]);
      end else begin
        nx = ex[i] - 2;
        if (ex[i] + 52 >= 160 && nx + 52 < 160) any = 1'b1;
        ex[i] = nx;
      end
    end
    exp_pulse = any && (exp_score < 9999);
    if (any && exp_score < 9999) exp_score++;
  endtask

  task automatic check_pipes(input string tag);
    check({tag, " pipe1"}, pipe1, {16'(ex[0]), 16'(eg[0])});
    check({tag, " pipe2"}, pipe2, {16'(ex[1]), 16'(eg[1])});
    check({tag, " pipe3"}, pipe3, {16'(ex[2]), 16'(eg[2])});
  endtask

  // One frame tick in RUN, then one idle clock
  task automatic run_tick();
    logic [15:0] l;
    l = m_lfsr;
    frame_tick = 1'b1;
    model_tick(l);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    check_pipes("tick");
    check("tick score", {16'd0, score}, {16'd0, to_bcd(exp_score)});
    check("tick pulse", {31'd0, score_pulse}, {31'd0, exp_pulse});
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        r;
    logic        u;
    logic        t;
    logic        f;
    logic [1:0]  st;
    logic [31:0] p1;
  } vec_t;

  vec_t vecs [16];

  initial begin
    rst = 1'b1; up = 1'b0; frame_tick = 1'b0; fail = 1'b0;
    c_rst = 1'b1; c_clr = 1'b0; c_inc = 1'b0;

    // FSM transition table: one row per clock
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0280_00C8};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0280_00C8};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0280_00C8};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0280_00C8};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0280_00C8};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 32'h0280_00C8};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0280_00C8};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0280_00C8};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0280_00C8};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0280_00C8};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0280_00C8};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'h027E_00C8};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 32'h027E_00C8};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h027E_00C8};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h027E_00C8};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0280_00C8};

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].r; up = vecs[i].u; frame_tick = vecs[i].t; fail = vecs[i].f;
      @(posedge clk); #1;
      check($sformatf("vec%0d state", i), {30'd0, state}, {30'd0, vecs[i].st});
      check($sformatf("vec%0d pipe1", i), pipe1, vecs[i].p1);
      if (i == 0) begin
        check("reset pipe2", pipe2, 32'h0370_00A0);
        check("reset pipe3", pipe3, 32'h0460_00F0);
        check("reset score", {16'd0, score}, 32'd0);
      end
    end

    // Fresh reset, then a long RUN against the model
    up = 1'b0; frame_tick = 1'b0; fail = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    up = 1'b1;
    @(posedge clk); #1;
    up = 1'b0;
    check("run state", {30'd0, state}, 32'd1);

    for (int n = 1; n <= 1347; n++) begin
      run_tick();
      if (n == 10) begin
        check("t10 pipe1 x", {16'd0, pipe1[31:16]}, 32'd620);
        check("t10 pipe3 x", {16'd0, pipe3[31:16]}, 32'd1100);
        check("t10 score", {16'd0, score}, 32'd0);
      end
      if (n == 320) check("respawn pipe1 x", {16'd0, pipe1[31:16]}, 32'd720);
      if (n == 1346) begin
        check("pre-score pipe1 x", {16'd0, pipe1[31:16]}, 32'd108);
        check("pre-score score", {16'd0, score}, 32'h0009);
      end
      if (n == 1347) begin
        check("score pipe1 x", {16'd0, pipe1[31:16]}, 32'd106);
        check("score bcd carry", {16'd0, score}, 32'h0010);
        check("pulse drops", {31'd0, score_pulse}, 32'd0);
      end
    end

    // fail with coincident tick: freeze, then ignore ticks
    fail = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    fail = 1'b0; frame_tick = 1'b0;
    check("dead state", {30'd0, state}, 32'd2);
    check_pipes("dead");
    check("dead score", {16'd0, score}, 32'h0010);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    check_pipes("dead tick");
    check("dead tick state", {30'd0, state}, 32'd2);
    up = 1'b1;
    @(posedge clk); #1;
    up = 1'b0;
    check("restore state", {30'd0, state}, 32'd0);
    check("restore pipe1", pipe1, 32'h0280_00C8);
    check("restore pipe2", pipe2, 32'h0370_00A0);
    check("restore pipe3", pipe3, 32'h0460_00F0);
    check("restore score", {16'd0, score}, 32'd0);

    // Reset in the middle of a tick clock
    model_reset();
    @(posedge clk); #1;
    up = 1'b1;
    @(posedge clk); #1;
    up = 1'b0;
    for (int n = 0; n < 3; n++) run_tick();
    check("run3 pipe1 x", {16'd0, pipe1[31:16]}, 32'd634);
    rst = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; frame_tick = 1'b0;
    check("midrst state", {30'd0, state}, 32'd0);
    check("midrst pipe1", pipe1, 32'h0280_00C8);
    check("midrst pipe2", pipe2, 32'h0370_00A0);
    check("midrst pipe3", pipe3, 32'h0460_00F0);
    check("midrst score", {16'd0, score}, 32'd0);
    check("midrst pulse", {31'd0, score_pulse}, 32'd0);

    // Standalone counter: carries and saturation
    c_rst = 1'b1;
    @(posedge clk); #1;
    c_rst = 1'b0;
    check("cnt reset", {16'd0, c_bcd}, 32'd0);
    c_inc = 1'b1;
    for (int k = 1; k <= 10001; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 9 || k == 10 || k == 99 || k == 100 || k == 1000 ||
          k == 9999 || k == 10000 || k == 10001) begin
        check($sformatf("cnt %0d bcd", k), {16'd0, c_bcd}, {16'd0, to_bcd(k)});
        check($sformatf("cnt %0d changed", k), {31'd0, c_chg}, {31'd0, (k <= 9999)});
      end
    end
    c_inc = 1'b0; c_clr = 1'b1;
    @(posedge clk); #1;
    c_clr = 1'b0;
    check("cnt clear", {16'd0, c_bcd}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
